// File: rtl/udar_pkg.sv
// Shared definitions for the ultrasonic ranging blocks (trigger generator and
// echo measurement).
package udar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_MEASURE   = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // clk cycles per timing tick; 1 us at 50 MHz, same base as the trigger block
    localparam int TICK_DIV_DEFAULT = 50;

endpackage

// File: rtl/echo_meas_if.sv
// Request/result handshake between the echo measurement block and the
// distance logic that consumes its results.
interface echo_meas_if #(
    parameter int CNT_LEN = 16
);
    logic               start;
    logic [CNT_LEN-1:0] timeout;
    logic               ack;
    logic               busy;
    logic               valid;
    logic [CNT_LEN-1:0] width;
    logic               tout;

    modport master (
        output start, timeout, ack,
        input  busy, valid, width, tout
    );

    modport slave (
        input  start, timeout, ack,
        output busy, valid, width, tout
    );
endinterface

// File: rtl/echo_sync.sv
// Brings the raw echo into the clk domain and flags its edges one cycle wide.
module echo_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], echo};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/echo_meas.sv
// Waits for the echo rising edge after a trigger, measures the high time in
// prescaled ticks and hands the width (or a timeout) to the consumer.
module echo_meas
    import udar_pkg::*;
#(
    parameter int CNT_LEN     = 16,
    parameter int TICK_DIV    = TICK_DIV_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       echo,
    echo_meas_if.slave bus
);

    localparam int               PRE_W   = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    state_t             state_reg, state_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic [CNT_LEN-1:0] cnt_reg, cnt_next;
    logic [CNT_LEN-1:0] width_reg, width_next;
    logic               tout_reg, tout_next;

    logic               echo_level;
    logic               echo_rise;
    logic               echo_fall;
    logic               pulse_end;
    logic               tick;
    logic [CNT_LEN:0]   cnt_inc;
    logic               limit;

    echo_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .echo (echo),
        .level(echo_level),
        .rise (echo_rise),
        .fall (echo_fall)
    );

    // a fall always coincides with the synchronized level being low
    assign pulse_end = echo_fall & ~echo_level;

    assign tick    = (pre_reg == PRE_MAX);
    // one bit wider so a timeout at the counter's full scale still compares correctly
    assign cnt_inc = {1'b0, cnt_reg} + {{CNT_LEN{1'b0}}, 1'b1};
    assign limit   = (cnt_inc >= {1'b0, bus.timeout});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            pre_reg   <= '0;
            cnt_reg   <= '0;
            width_reg <= '0;
            tout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            cnt_reg   <= cnt_next;
            width_reg <= width_next;
            tout_reg  <= tout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pre_next   = tick ? '0 : pre_reg + PRE_W'(1);
        cnt_next   = cnt_reg;
        width_next = width_reg;
        tout_next  = tout_reg;

        case (state_reg)
            ST_IDLE: begin
                pre_next = '0;
                if (bus.start) begin
                    state_next = ST_WAIT_RISE;
                    cnt_next   = '0;
                end
            end

            ST_WAIT_RISE: begin
                if (echo_rise) begin
                    state_next = ST_MEASURE;
                    cnt_next   = '0;
                    pre_next   = '0;
                end else if (tick) begin
                    if (limit) begin
                        state_next = ST_DONE;
                        width_next = '0;
                        tout_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_inc[CNT_LEN-1:0];
                    end
                end
            end

            ST_MEASURE: begin
                // the tick coinciding with the fall is deliberately not counted
                if (pulse_end) begin
                    state_next = ST_DONE;
                    width_next = cnt_reg;
                    tout_next  = 1'b0;
                end else if (tick) begin
                    if (limit) begin
                        state_next = ST_DONE;
                        width_next = bus.timeout;
                        tout_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_inc[CNT_LEN-1:0];
                    end
                end
            end

            ST_DONE: begin
                pre_next = '0;
                if (bus.ack) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                pre_next   = '0;
            end
        endcase
    end

    assign bus.busy  = (state_reg != ST_IDLE);
    assign bus.valid = (state_reg == ST_DONE);
    assign bus.width = width_reg;
    assign bus.tout  = tout_reg;

endmodule

// File: tb/tb_echo_meas.sv
// Directed and randomized echo scenarios against a cycle-level arithmetic model.
module tb_echo_meas;

    localparam int CNT_LEN     = 8;
    localparam int TICK_DIV    = 4;
    localparam int SYNC_STAGES = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic echo = 1'b0;

    echo_meas_if #(.CNT_LEN(CNT_LEN)) bus ();

    echo_meas #(
        .CNT_LEN    (CNT_LEN),
        .TICK_DIV   (TICK_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .echo(echo),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Timing reference: cycle c starts at the c-th falling edge after the start
    // pulse is driven (c=0); posedge number c+1 ends it.  An echo change driven in
    // cycle c is seen as an edge by the FSM during cycle c+2 (two sync flops), and
    // the WAIT_RISE phase begins right after posedge 1.  Within a phase the n-th
    // tick occurs in phase-cycle n*TICK_DIV-1, so the deciding tick of a limit
    // is tick max(timeout,1).
    function automatic void model(input int a, input int h, input int t,
                                  output int done_p, output int w, output int to);
        int lim;
        int r;
        lim = ((t < 1) ? 1 : t) * TICK_DIV - 1;
        r   = a + 1;                     // WAIT_RISE cycle in which the rise is seen
        if (r > lim) begin
            done_p = lim + 2;
            w      = 0;
            to     = 1;
        end else if (h - 1 <= lim) begin
            // MEASURE lasts h cycles; the fall cycle's own tick is not counted
            done_p = a + h + 3;
            w      = (h - 1) / TICK_DIV;
            to     = 0;
        end else begin
            done_p = a + lim + 4;
            w      = t;
            to     = 1;
        end
    endfunction

    // f: echo high (stale) until cycle f; rise at cycle a; high for h cycles.
    task automatic trial(input string tag, input int f, input int a, input int h,
                         input int t, input int extra_start, input int hold);
        int  done_p, w, to, p;
        bit  seen;
        model(a, h, t, done_p, w, to);
        @(negedge clk);
        echo        = (f > 0);
        bus.timeout = 8'(t);
        repeat (4) @(negedge clk);
        seen = 1'b0;
        p    = 0;
        for (int c = 0; c < done_p + 10 && !seen; c++) begin
            if (c > 0) @(negedge clk);
            bus.start = (c == 0) || (c == extra_start);
            echo      = (c < f) || (c >= a && c < a + h);
            @(posedge clk);
            #1;
            if (c == 0) check({tag, "/busy_after_start"}, bus.busy, 1);
            if (bus.valid) begin
                seen = 1'b1;
                p    = c + 1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "/valid_edge"}, p, done_p);
        check({tag, "/width"}, bus.width, w);
        check({tag, "/tout"}, bus.tout, to);
        if (hold > 0) begin
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            repeat (hold) @(negedge clk);
            check({tag, "/hold_valid"}, bus.valid, 1);
            check({tag, "/hold_width"}, bus.width, w);
            check({tag, "/hold_tout"}, bus.tout, to);
        end
        bus.ack = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "/ack_valid"}, bus.valid, 0);
        check({tag, "/ack_busy"}, bus.busy, 0);
        @(negedge clk);
        bus.ack = 1'b0;
        $display("trial %s f=%0d a=%0d h=%0d t=%0d -> edge=%0d width=%0d tout=%0d",
                 tag, f, a, h, t, p, bus.width, bus.tout);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int ra, rh, rt, rf;
        bus.start   = 1'b0;
        bus.ack     = 1'b0;
        bus.timeout = 8'd20;

        // reset state
        #12;
        check("reset/busy", bus.busy, 0);
        check("reset/valid", bus.valid, 0);
        check("reset/width", bus.width, 0);
        check("reset/tout", bus.tout, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        trial("t1_normal", 0, 10, 42, 20, -1, 0);
        trial("t2_no_echo", 0, 200, 10, 20, -1, 0);
        trial("t3_long_high", 0, 5, 200, 20, -1, 0);
        trial("t3_restart_high", 30, 40, 20, 20, -1, 0);
        trial("t4_stale", 8, 20, 42, 20, -1, 0);
        trial("t5_start_ignored", 0, 10, 42, 20, 25, 50);
        trial("t5_timeout_zero", 0, 10, 20, 0, -1, 0);
        trial("t6_pre", 0, 3, 150, 20, -1, 0);

        // asynchronous reset in the middle of MEASURE
        @(negedge clk);
        bus.timeout = 8'd20;
        echo        = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        echo      = 1'b1;
        repeat (12) @(negedge clk);
        check("t6/busy_before_rst", bus.busy, 1);
        check("t6/width_before_rst", bus.width, 20);
        #2;
        rst = 1'b0;
        #1;
        check("t6/rst_busy", bus.busy, 0);
        check("t6/rst_valid", bus.valid, 0);
        check("t6/rst_width", bus.width, 0);
        check("t6/rst_tout", bus.tout, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("t6/idle_after_rst", bus.busy, 0);
        check("t6/no_valid_after_rst", bus.valid, 0);
        trial("t6_fresh_rise", 5, 15, 30, 20, -1, 0);

        for (int i = 0; i < 14; i++) begin
            rt = $urandom_range(0, 30);
            ra = $urandom_range(0, 60);
            rh = $urandom_range(1, 100);
            rf = 0;
            if (ra >= 6 && $urandom_range(0, 1) == 1) rf = $urandom_range(1, ra - 4);
            trial($sformatf("rnd%0d", i), rf, ra, rh, rt, -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
